// File: rtl/dispense_arbiter_pkg.sv
// Shared encodings and default sizing for the dispenser pump/counter arbiter.
// Other shared-resource controllers import the state type and defaults from here.
package dispense_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_LOAD     = 2'b01,
    ST_DISPENSE = 2'b10,
    ST_GAP      = 2'b11
  } state_t;

  localparam int DEF_N_CH    = 4;
  localparam int DEF_VOL_W   = 8;
  localparam int DEF_GAP_CYC = 4;

  // Width of a counter that must hold values 0..n-1, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dispense_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping to 0.
// Pure logic, no state; pick is one-hot or zero, idx is its binary index.
module dispense_arbiter_rr_pick
  import dispense_arbiter_pkg::*;
#(
  parameter int N_CH  = DEF_N_CH,
  parameter int IDX_W = cnt_width(DEF_N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_CH-1:0]  pick,
  output logic [IDX_W-1:0] idx
);

  int               cand_int;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    pick     = '0;
    idx      = '0;
    found    = 1'b0;
    cand_int = 0;
    cand     = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand_int = int'(ptr) + k;
      if (cand_int >= N_CH) begin
        cand_int = cand_int - N_CH;
      end
      cand = IDX_W'(cand_int);
      if (!found && req[cand]) begin
        found     = 1'b1;
        pick[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/dispense_arbiter.sv
// Shares one pump and volume counter among N_CH channels: round-robin grant, latch volume,
// count flow ticks to zero, then hold all valves closed for GAP_CYC cycles before re-arbitrating.
module dispense_arbiter
  import dispense_arbiter_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int VOL_W   = DEF_VOL_W,
  parameter int GAP_CYC = DEF_GAP_CYC
) (
  input  logic                  clk,
  input  logic                  RESET,
  input  logic [N_CH-1:0]       req,
  input  logic [N_CH*VOL_W-1:0] vol,
  input  logic                  tick,
  input  logic                  abort,
  output logic [N_CH-1:0]       grant,
  output logic [N_CH-1:0]       valve,
  output logic [VOL_W-1:0]      remain,
  output logic [N_CH-1:0]       done,
  output logic                  aborted,
  output logic                  busy
);

  localparam int IDX_W = cnt_width(N_CH);
  localparam int GAP_W = cnt_width(GAP_CYC);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] gidx, gidx_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic [N_CH-1:0]  grant_nxt, valve_nxt, done_nxt;
  logic [VOL_W-1:0] remain_nxt;
  logic             aborted_nxt, busy_nxt;
  logic             go_gap;

  logic [N_CH-1:0]  pick;
  logic [IDX_W-1:0] pick_idx;
  logic [VOL_W-1:0] vol_arr [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_vol
    assign vol_arr[i] = vol[i*VOL_W +: VOL_W];
  end

  dispense_arbiter_rr_pick #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!RESET) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      gidx    <= '0;
      gap_cnt <= '0;
      grant   <= '0;
      valve   <= '0;
      remain  <= '0;
      done    <= '0;
      aborted <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gidx    <= gidx_nxt;
      gap_cnt <= gap_nxt;
      grant   <= grant_nxt;
      valve   <= valve_nxt;
      remain  <= remain_nxt;
      done    <= done_nxt;
      aborted <= aborted_nxt;
      busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    gidx_nxt    = gidx;
    gap_nxt     = gap_cnt;
    grant_nxt   = grant;
    valve_nxt   = valve;
    remain_nxt  = remain;
    done_nxt    = '0;
    aborted_nxt = 1'b0;
    busy_nxt    = busy;
    go_gap      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (|req) begin
          grant_nxt  = pick;
          gidx_nxt   = pick_idx;
          remain_nxt = vol_arr[pick_idx];
          busy_nxt   = 1'b1;
          state_nxt  = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (remain == '0) begin
          done_nxt = grant;
          go_gap   = 1'b1;
        end else begin
          valve_nxt = grant;
          state_nxt = ST_DISPENSE;
        end
      end

      ST_DISPENSE: begin
        // Abort takes priority over a coincident tick so the reported remainder is exact.
        if (abort) begin
          aborted_nxt = 1'b1;
          go_gap      = 1'b1;
        end else if (tick) begin
          if (remain <= VOL_W'(1)) begin
            remain_nxt = '0;
            done_nxt   = grant;
            go_gap     = 1'b1;
          end else begin
            remain_nxt = remain - VOL_W'(1);
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_nxt  = ST_IDLE;
          busy_nxt   = 1'b0;
          remain_nxt = '0;
        end else begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (go_gap) begin
      state_nxt = ST_GAP;
      gap_nxt   = GAP_W'(GAP_CYC - 1);
      ptr_nxt   = (gidx == IDX_W'(N_CH - 1)) ? '0 : gidx + IDX_W'(1);
      valve_nxt = '0;
      grant_nxt = '0;
    end
  end

endmodule

// File: tb/tb_dispense_arbiter.sv
// Randomized and scenario-driven bench for dispense_arbiter against a transaction-level model.
module tb_dispense_arbiter;

  localparam int N_CH    = 4;
  localparam int VOL_W   = 8;
  localparam int GAP_CYC = 4;

  logic                  clk;
  logic                  RESET;
  logic [N_CH-1:0]       req;
  logic [N_CH*VOL_W-1:0] vol;
  logic                  tick;
  logic                  abort;
  logic [N_CH-1:0]       grant;
  logic [N_CH-1:0]       valve;
  logic [VOL_W-1:0]      remain;
  logic [N_CH-1:0]       done;
  logic                  aborted;
  logic                  busy;

  dispense_arbiter #(
    .N_CH    (N_CH),
    .VOL_W   (VOL_W),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk     (clk),
    .RESET   (RESET),
    .req     (req),
    .vol     (vol),
    .tick    (tick),
    .abort   (abort),
    .grant   (grant),
    .valve   (valve),
    .remain  (remain),
    .done    (done),
    .aborted (aborted),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs, advanced once per rising edge by the model process.
  logic [N_CH-1:0]  e_grant   = '0;
  logic [N_CH-1:0]  e_valve   = '0;
  logic [N_CH-1:0]  e_done    = '0;
  logic [VOL_W-1:0] e_remain  = '0;
  logic             e_aborted = 1'b0;
  logic             e_busy    = 1'b0;
  int               m_ptr     = 0;

  function automatic logic [N_CH-1:0] onehot(input int i);
    return N_CH'(1) << i;
  endfunction

  function automatic int rr_choose(input logic [N_CH-1:0] r, input int p);
    logic [N_CH-1:0] sh;
    for (int k = 0; k < N_CH; k++) begin
      sh = r >> ((p + k) % N_CH);
      if (sh[0]) return (p + k) % N_CH;
    end
    return -1;
  endfunction

  function automatic logic [VOL_W-1:0] vol_of(input logic [N_CH*VOL_W-1:0] v, input int ch);
    logic [N_CH*VOL_W-1:0] sh;
    sh = v >> (ch * VOL_W);
    return sh[VOL_W-1:0];
  endfunction

  task automatic mstep(output bit r);
    @(posedge clk);
    e_done    = '0;
    e_aborted = 1'b0;
    r = !RESET;
    if (r) begin
      e_grant  = '0;
      e_valve  = '0;
      e_remain = '0;
      e_busy   = 1'b0;
      m_ptr    = 0;
    end
  endtask

  // One dispense per iteration: arbitrate, load, count ticks, then the closed-valve gap.
  initial begin : model
    bit r;
    int g;
    forever begin
      mstep(r);
      if (r || req == '0) continue;
      g        = rr_choose(req, m_ptr);
      e_grant  = onehot(g);
      e_remain = vol_of(vol, g);
      e_busy   = 1'b1;
      mstep(r);
      if (r) continue;
      if (e_remain == '0) begin
        e_done  = onehot(g);
        e_grant = '0;
      end else begin
        e_valve = onehot(g);
        forever begin
          mstep(r);
          if (r) break;
          if (abort) begin
            e_aborted = 1'b1;
            e_valve   = '0;
            e_grant   = '0;
            break;
          end
          if (tick) begin
            e_remain = e_remain - 1'b1;
            if (e_remain == '0) begin
              e_done  = onehot(g);
              e_valve = '0;
              e_grant = '0;
              break;
            end
          end
        end
        if (r) continue;
      end
      m_ptr = (g + 1) % N_CH;
      for (int k = 0; k < GAP_CYC; k++) begin
        mstep(r);
        if (r) break;
      end
      if (r) continue;
      e_busy   = 1'b0;
      e_remain = '0;
    end
  end

  // Grant-start recorder for order checks.
  bit              rec_en = 1'b0;
  logic [N_CH-1:0] prev_grant = '0;
  logic [N_CH-1:0] rec_q[$];

  task automatic cyc();
    @(negedge clk);
    chk("grant",   32'(grant),   32'(e_grant));
    chk("valve",   32'(valve),   32'(e_valve));
    chk("remain",  32'(remain),  32'(e_remain));
    chk("done",    32'(done),    32'(e_done));
    chk("aborted", 32'(aborted), 32'(e_aborted));
    chk("busy",    32'(busy),    32'(e_busy));
    if (rec_en && grant != '0 && prev_grant == '0) rec_q.push_back(grant);
    prev_grant = grant;
  endtask

  task automatic set_vol(input int ch, input int v);
    vol[ch*VOL_W +: VOL_W] = VOL_W'(v);
  endtask

  task automatic do_reset();
    req   = '0;
    vol   = '0;
    tick  = 1'b0;
    abort = 1'b0;
    RESET = 1'b0;
    cyc();
    cyc();
    RESET = 1'b1;
  endtask

  // Hold req (dropping finished channels unless held) and tick every tick_per cycles.
  task automatic run(input int n, input int tick_per, input bit hold);
    for (int i = 0; i < n; i++) begin
      cyc();
      if (!hold) req = req & ~e_done;
      tick = (tick_per > 0) && (i % tick_per == tick_per - 1);
    end
  endtask

  initial begin : stim
    bit found;
    RESET = 1'b0;
    req   = '0;
    vol   = '0;
    tick  = 1'b0;
    abort = 1'b0;

    do_reset();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valve", 32'(valve), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);

    // Single request, ticks spaced five cycles apart.
    set_vol(1, 3);
    req = 4'b0010;
    run(30, 5, 1'b0);

    // Round-robin order with req held and unit volumes.
    do_reset();
    for (int c = 0; c < N_CH; c++) set_vol(c, 1);
    rec_q.delete();
    rec_en = 1'b1;
    req = 4'b1011;
    run(30, 1, 1'b1);
    req = '0;
    run(10, 1, 1'b0);
    rec_en = 1'b0;
    chk("rr_count", 32'(rec_q.size() >= 4), 32'd1);
    if (rec_q.size() >= 4) begin
      chk("rr_0", 32'(rec_q[0]), 32'h1);
      chk("rr_1", 32'(rec_q[1]), 32'h2);
      chk("rr_2", 32'(rec_q[2]), 32'h8);
      chk("rr_3", 32'(rec_q[3]), 32'h1);
    end

    // Zero volume on channel 2, then ptr must favour channel 3.
    do_reset();
    set_vol(2, 0);
    req = 4'b0100;
    run(8, 0, 1'b0);
    rec_q.delete();
    rec_en = 1'b1;
    set_vol(0, 1);
    set_vol(3, 1);
    req = 4'b1001;
    run(12, 1, 1'b0);
    rec_en = 1'b0;
    chk("zv_next", 32'(rec_q.size() > 0 ? rec_q[0] : '0), 32'h8);
    req = '0;
    run(10, 0, 1'b0);

    // Abort coinciding with a tick at remain=3.
    do_reset();
    set_vol(0, 5);
    req   = 4'b0001;
    tick  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (e_valve != '0 && e_remain == 3) begin
        found = 1'b1;
        break;
      end
    end
    chk("abort_armed", 32'(found), 32'd1);
    abort = 1'b1;
    tick  = 1'b1;
    cyc();
    chk("abort_pulse",  32'(aborted), 32'd1);
    chk("abort_remain", 32'(remain),  32'd3);
    chk("abort_done",   32'(done),    32'd0);
    chk("abort_valve",  32'(valve),   32'd0);
    abort = 1'b0;
    req   = '0;
    run(8, 1, 1'b0);

    // Reset mid-dispense, then channel 3 alone.
    do_reset();
    set_vol(0, 4);
    req   = 4'b0001;
    tick  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (e_valve == 4'b0001 && e_remain == 2) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_armed", 32'(found), 32'd1);
    RESET = 1'b0;
    tick  = 1'b0;
    cyc();
    chk("mid_grant",  32'(grant),  32'd0);
    chk("mid_valve",  32'(valve),  32'd0);
    chk("mid_remain", 32'(remain), 32'd0);
    chk("mid_busy",   32'(busy),   32'd0);
    RESET = 1'b1;
    set_vol(3, 2);
    rec_q.delete();
    rec_en = 1'b1;
    req = 4'b1000;
    run(12, 1, 1'b0);
    rec_en = 1'b0;
    chk("mid_regrant", 32'(rec_q.size() > 0 ? rec_q[0] : '0), 32'h8);

    // Stray ticks while idle.
    req = '0;
    run(6, 1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if ($urandom % 8 == 0) req = N_CH'($urandom);
      req = req & ~e_done;
      if ($urandom % 6 == 0) set_vol(int'($urandom % N_CH), int'($urandom_range(0, 5)));
      tick  = 1'($urandom % 2);
      abort = ($urandom % 24 == 0);
      RESET = ($urandom % 300 != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
